// File: rtl/freq_meter_mc_if.sv
// -----------------------------------------------------------------------------
// freq_meter_mc_if
// Bundles the control, test-signal and result signals of freq_meter_mc.
//   en         : block enable, low aborts any measurement
//   mode       : 0 = single-shot, 1 = continuous
//   start      : single-shot trigger, level-sampled while idle
//   sig_in     : CH asynchronous test signals
//   busy       : high while gating or calculating
//   freq_valid : one-cycle pulse when new results are loaded
//   freq_data  : CH results of CNT_W bits each, channel i at [i*CNT_W +: CNT_W]
//   ovf        : per-channel overflow flag of the last completed measurement
// Modports: master drives the controls (testbench/host), slave is the meter.
// -----------------------------------------------------------------------------
interface freq_meter_mc_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 32
);
    logic                  en;
    logic                  mode;
    logic                  start;
    logic [CH-1:0]         sig_in;
    logic                  busy;
    logic                  freq_valid;
    logic [CH*CNT_W-1:0]   freq_data;
    logic [CH-1:0]         ovf;

    modport master (
        output en, mode, start, sig_in,
        input  busy, freq_valid, freq_data, ovf
    );

    modport slave (
        input  en, mode, start, sig_in,
        output busy, freq_valid, freq_data, ovf
    );
endinterface

// File: rtl/freq_meter_mc.sv
// -----------------------------------------------------------------------------
// freq_meter_mc
// Multi-channel frequency meter in the system clock domain. Rising edges of
// each synchronized test signal are counted over a GATE_CYCLES window, then
// scaled channel by channel to Hz and published with a one-cycle valid pulse.
// Ports:
//   clk   : system clock (SYS_CLK_FREQ Hz)
//   rst_n : asynchronous active-low reset
//   bus   : freq_meter_mc_if.slave (controls, test signals, results)
// Optional feature: define FREQ_METER_MC_GLITCH_FILTER_EN to add a per-channel
// 3-sample majority-free glitch filter (pulses shorter than 3 cycles are
// rejected, input-to-count latency grows from 3 to 5 cycles).
// -----------------------------------------------------------------------------
module freq_meter_mc #(
    parameter int CH           = 4,
    parameter int CNT_W        = 32,
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int GATE_CYCLES  = 100_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    freq_meter_mc_if.slave  bus
);
    localparam int SCALE   = SYS_CLK_FREQ / GATE_CYCLES;
    localparam int SCALE_W = $clog2(SCALE + 1);
    localparam int PROD_W  = CNT_W + SCALE_W;
    localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int IDX_W   = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [CH-1:0]       r_s1;
    logic [CH-1:0]       r_s2;
    logic [CH-1:0]       r_s3;
    logic [CH-1:0]       w_rise;

    logic [GATE_W-1:0]   r_gate_cnt;
    logic [CNT_W-1:0]    r_cnt [CH];
    logic [CH-1:0]       r_sat;
    logic                w_enter_gate;

    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_res [CH];
    logic [CH-1:0]       r_ovf_next;
    logic [PROD_W-1:0]   w_prod;
    logic [CNT_W-1:0]    w_res_cur;
    logic                w_ovf_cur;
    logic [CH*CNT_W-1:0] w_data_next;
    logic [CH-1:0]       w_ovf_all;

    logic                r_busy;
    logic                r_freq_valid;
    logic [CH*CNT_W-1:0] r_freq_data;
    logic [CH-1:0]       r_ovf;

    // Two-flop synchronizer followed by one history flop per channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= bus.sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

`ifdef FREQ_METER_MC_GLITCH_FILTER_EN
    logic [CH-1:0] r_s4;
    logic [CH-1:0] r_s5;
    logic [CH-1:0] w_filt;

    // Filtered level follows s2 only after three equal samples; r_s5 holds the
    // previous filtered level, so the edge is seen as soon as the filter moves
    always_comb begin
        w_filt = r_s5;
        for (int i = 0; i < CH; i++) begin
            if ((r_s2[i] == r_s3[i]) && (r_s3[i] == r_s4[i])) begin
                w_filt[i] = r_s2[i];
            end else begin
                w_filt[i] = r_s5[i];
            end
        end
        w_rise = w_filt & ~r_s5;
    end

    // Extra history flop and filtered-level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s4 <= '0;
            r_s5 <= '0;
        end else begin
            r_s4 <= r_s3;
            r_s5 <= w_filt;
        end
    end
`else
    assign w_rise = r_s2 & ~r_s3;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; en low aborts from every state
    always_comb begin
        w_state_next = r_state;
        if (!bus.en) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mode | bus.start) w_state_next = S_GATE;
                    else                      w_state_next = S_IDLE;
                end
                S_GATE: begin
                    if (r_gate_cnt == GATE_LAST) w_state_next = S_CALC;
                    else                         w_state_next = S_GATE;
                end
                S_CALC: begin
                    if (r_idx == IDX_LAST) w_state_next = S_DONE;
                    else                   w_state_next = S_CALC;
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_enter_gate = (r_state == S_IDLE) && (w_state_next == S_GATE);

    // Gate counter and saturating edge counters; the last gate cycle still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_sat      <= '0;
            for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
        end else if (w_enter_gate) begin
            r_gate_cnt <= '0;
            r_sat      <= '0;
            for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
        end else if (r_state == S_GATE) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            for (int i = 0; i < CH; i++) begin
                if (w_rise[i]) begin
                    if (r_cnt[i] == CNT_MAX) r_sat[i] <= 1'b1;
                    else                     r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Scale the channel selected by r_idx, clamping on product overflow or
    // counter saturation
    always_comb begin
        w_prod = PROD_W'(r_cnt[r_idx]) * PROD_W'(SCALE);
        if (r_sat[r_idx] || (w_prod > PROD_W'(CNT_MAX))) begin
            w_res_cur = CNT_MAX;
            w_ovf_cur = 1'b1;
        end else begin
            w_res_cur = w_prod[CNT_W-1:0];
            w_ovf_cur = 1'b0;
        end
    end

    // Channel index walks 0..CH-1 during CALC and storing per-channel results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_ovf_next <= '0;
            for (int i = 0; i < CH; i++) r_res[i] <= '0;
        end else if (r_state == S_CALC) begin
            r_idx             <= r_idx + IDX_W'(1);
            r_res[r_idx]      <= w_res_cur;
            r_ovf_next[r_idx] <= w_ovf_cur;
        end else begin
            r_idx <= '0;
        end
    end

    // The last channel is still being computed on the CALC->DONE edge, so the
    // output image merges it in directly instead of waiting a cycle
    always_comb begin
        w_data_next = '0;
        w_ovf_all   = '0;
        for (int i = 0; i < CH; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_data_next[i*CNT_W +: CNT_W] = w_res_cur;
                w_ovf_all[i]                  = w_ovf_cur;
            end else begin
                w_data_next[i*CNT_W +: CNT_W] = r_res[i];
                w_ovf_all[i]                  = r_ovf_next[i];
            end
        end
    end

    // Registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_freq_valid <= 1'b0;
            r_freq_data  <= '0;
            r_ovf        <= '0;
        end else begin
            r_busy       <= (w_state_next == S_GATE) || (w_state_next == S_CALC);
            r_freq_valid <= (w_state_next == S_DONE);
            if (w_state_next == S_DONE) begin
                r_freq_data <= w_data_next;
                r_ovf       <= w_ovf_all;
            end else begin
                r_freq_data <= r_freq_data;
                r_ovf       <= r_ovf;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.freq_valid = r_freq_valid;
    assign bus.freq_data  = r_freq_data;
    assign bus.ovf        = r_ovf;

endmodule
